usb_rx_word_packer: RTL

Write-side feeder for the dual-port endpoint packet buffer RAM. Packs the USB receive byte stream from the SIE into 32-bit little-endian words and issues masked single-cycle writes on RAM port A. Reports packet completion, byte count and overflow to the endpoint control logic. Single clock domain, same clock as RAM port A.

---
 rtl/usb_rx_word_packer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/usb_rx_word_packer.sv
// Packs the SIE receive byte stream into 32-bit little-endian words for RAM port A.
// Optional: define USB_RX_PACKER_ZERO_FILL_EN to make flush writes clear unused lanes.
module usb_rx_word_packer #(
  parameter int unsigned Width       = 32,
  parameter int unsigned Depth       = 1024,
  parameter int unsigned MaxPktBytes = 64
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               pkt_start_i,
  input  logic [31:0]                        buf_base_i,
  input  logic                               rx_valid_i,
  input  logic [7:0]                         rx_data_i,
  input  logic                               pkt_end_i,
  input  logic                               pkt_abort_i,
  output logic                               rx_ready_o,
  output logic                               ram_req_o,
  output logic                               ram_write_o,
  output logic [31:0]                        ram_addr_o,
  output logic [Width-1:0]                   ram_wdata_o,
  output logic [Width-1:0]                   ram_wmask_o,
  output logic                               pkt_done_o,
  output logic                               pkt_err_o,
  output logic [$clog2(MaxPktBytes+1)-1:0]   byte_cnt_o
);

  localparam int unsigned CW = $clog2(MaxPktBytes + 1);
  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;

  localparam logic [CW-1:0] MAX_CNT  = CW'(MaxPktBytes);
  localparam logic [AW-1:0] LAST_PTR = AW'(Depth - 1);

  logic [1:0]       state;
  logic [AW-1:0]    ptr;
  logic [CW-1:0]    count;
  logic [Width-1:0] acc;
  logic [3:0]       lane_valid;

  logic [1:0]       lane;
  logic             accept;
  logic             overflow;
  logic             write_now;
  logic [Width-1:0] acc_nxt;
  logic [3:0]       valid_nxt;
  logic [Width-1:0] valid_mask;
  logic [Width-1:0] flush_mask;
  logic [AW-1:0]    ptr_nxt;
  logic [AW-1:0]    start_ptr;

  assign rx_ready_o  = (state == ACTIVE) || (state == DRAIN);
  assign ram_write_o = ram_req_o;
  assign byte_cnt_o  = count;

  // Merge the current byte into the accumulator view so a byte arriving with
  // pkt_end_i, or the byte completing lane 3, is part of the same write.
  always_comb begin
    lane      = count[1:0];
    accept    = (state == ACTIVE) && rx_valid_i && (count < MAX_CNT);
    overflow  = (state == ACTIVE) && rx_valid_i && (count == MAX_CNT);
    acc_nxt   = acc;
    valid_nxt = lane_valid;
    for (int unsigned i = 0; i < 4; i++) begin
      if (accept && (lane == 2'(i))) begin
        acc_nxt[8*i +: 8] = rx_data_i;
        valid_nxt[i]      = 1'b1;
      end
    end
    for (int unsigned i = 0; i < 4; i++) begin
      valid_mask[8*i +: 8] = {8{valid_nxt[i]}};
    end
`ifdef USB_RX_PACKER_ZERO_FILL_EN
    flush_mask = '1;
`else
    flush_mask = valid_mask;
`endif
    write_now = (accept && (lane == 2'd3)) ||
                (((state == ACTIVE) || (state == DRAIN)) && pkt_end_i && (|valid_nxt));
    ptr_nxt   = (ptr == LAST_PTR) ? '0 : ptr + AW'(1);
    start_ptr = AW'(buf_base_i % 32'(Depth));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      ptr         <= '0;
      count       <= '0;
      acc         <= '0;
      lane_valid  <= '0;
      ram_req_o   <= 1'b0;
      ram_addr_o  <= '0;
      ram_wdata_o <= '0;
      ram_wmask_o <= '0;
      pkt_done_o  <= 1'b0;
      pkt_err_o   <= 1'b0;
    end else begin
      ram_req_o  <= 1'b0;
      pkt_done_o <= 1'b0;
      if (pkt_abort_i) begin
        state      <= IDLE;
        acc        <= '0;
        lane_valid <= '0;
      end else if (pkt_start_i) begin
        state      <= ACTIVE;
        ptr        <= start_ptr;
        count      <= '0;
        acc        <= '0;
        lane_valid <= '0;
        pkt_err_o  <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ACTIVE, DRAIN: begin
            if (accept) count <= count + CW'(1);
            if (overflow) pkt_err_o <= 1'b1;
            if (write_now) begin
              ram_req_o   <= 1'b1;
              ram_addr_o  <= 32'(ptr);
              ram_wdata_o <= acc_nxt;
              ram_wmask_o <= flush_mask;
              ptr         <= ptr_nxt;
              acc         <= '0;
              lane_valid  <= '0;
            end else begin
              acc        <= acc_nxt;
              lane_valid <= valid_nxt;
            end
            if (pkt_end_i) begin
              pkt_done_o <= 1'b1;
              state      <= IDLE;
            end else if (overflow) begin
              state <= DRAIN;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
